// File: rtl/slot_card_responder.sv
// Card-side virtual slot front end: scan-time slot discovery, bus decode, fixed-latency read return.
// Optional $C800 expansion-ROM support is enabled by defining SLOT_RESP_C8_EN.
module slot_card_responder #(
    parameter logic [7:0]  CARD_ID    = 8'd1,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk_logic,
    input  logic        system_reset_n,
    input  logic [2:0]  slot,
    input  logic [7:0]  card_id,
    input  logic        config_select_n,
    input  logic        dev_select_n,
    input  logic        io_select_n,
    input  logic        io_strobe_n,
    input  logic [15:0] addr,
    input  logic        rw_n,
    input  logic [7:0]  data_in,
    input  logic        bus_strobe,
    input  logic [7:0]  rdata_i,
    output logic        configured,
    output logic [2:0]  my_slot,
    output logic        reg_wr,
    output logic        reg_rd,
    output logic [3:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        cn_rd,
    output logic        c8_rd,
    output logic [10:0] rom_addr,
    output logic        c8_owner,
    output logic [7:0]  data_out,
    output logic        data_out_en
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {UNCONF, SCAN, ACTIVE, NOIDENT} state_t;

    state_t             state_q, state_d;
    logic               matched_q, matched_d;
    logic [2:0]         my_slot_q, my_slot_d;
    logic               configured_q, configured_d;
    logic               reg_wr_q, reg_wr_d;
    logic               reg_rd_q, reg_rd_d;
    logic [3:0]         reg_addr_q, reg_addr_d;
    logic [7:0]         reg_wdata_q, reg_wdata_d;
    logic               cn_rd_q, cn_rd_d;
    logic               c8_rd_q, c8_rd_d;
    logic [10:0]        rom_addr_q, rom_addr_d;
    logic               owner_q, owner_d;
    logic [7:0]         data_out_q, data_out_d;
    logic               data_out_en_q, data_out_en_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               read_pulse;

`ifndef SLOT_RESP_C8_EN
    // Without expansion-ROM support these inputs carry no meaning for the card.
    logic unused_c8;
    assign unused_c8 = ^{io_strobe_n, addr[15:8]};
`endif

    // State and output registers
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q       <= UNCONF;
            matched_q     <= 1'b0;
            my_slot_q     <= 3'd0;
            configured_q  <= 1'b0;
            reg_wr_q      <= 1'b0;
            reg_rd_q      <= 1'b0;
            reg_addr_q    <= 4'd0;
            reg_wdata_q   <= 8'd0;
            cn_rd_q       <= 1'b0;
            c8_rd_q       <= 1'b0;
            rom_addr_q    <= 11'd0;
            owner_q       <= 1'b0;
            data_out_q    <= 8'd0;
            data_out_en_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            matched_q     <= matched_d;
            my_slot_q     <= my_slot_d;
            configured_q  <= configured_d;
            reg_wr_q      <= reg_wr_d;
            reg_rd_q      <= reg_rd_d;
            reg_addr_q    <= reg_addr_d;
            reg_wdata_q   <= reg_wdata_d;
            cn_rd_q       <= cn_rd_d;
            c8_rd_q       <= c8_rd_d;
            rom_addr_q    <= rom_addr_d;
            owner_q       <= owner_d;
            data_out_q    <= data_out_d;
            data_out_en_q <= data_out_en_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next-state: read return, access decode, then scan (scan overrides on a rescan)
    always_comb begin
        state_d       = state_q;
        matched_d     = matched_q;
        my_slot_d     = my_slot_q;
        configured_d  = configured_q;
        reg_wr_d      = 1'b0;
        reg_rd_d      = 1'b0;
        reg_addr_d    = reg_addr_q;
        reg_wdata_d   = reg_wdata_q;
        cn_rd_d       = 1'b0;
        c8_rd_d       = 1'b0;
        rom_addr_d    = rom_addr_q;
        owner_d       = owner_q;
        data_out_d    = data_out_q;
        data_out_en_d = data_out_en_q;
        cnt_d         = cnt_q;
        read_pulse    = 1'b0;

        // Any strobe retires the previous read data and cancels a pending read.
        if (bus_strobe) begin
            data_out_en_d = 1'b0;
            cnt_d         = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                data_out_d    = rdata_i;
                data_out_en_d = 1'b1;
            end
        end

        if (state_q == ACTIVE && bus_strobe) begin
            if (!dev_select_n) begin
                if (slot == my_slot_q) begin
                    reg_addr_d = addr[3:0];
                    if (rw_n) begin
                        reg_rd_d   = 1'b1;
                        read_pulse = 1'b1;
                    end else begin
                        reg_wr_d    = 1'b1;
                        reg_wdata_d = data_in;
                    end
                end
            end else if (!io_select_n) begin
                if (slot == my_slot_q) begin
`ifdef SLOT_RESP_C8_EN
                    owner_d = 1'b1;
`endif
                    if (rw_n) begin
                        cn_rd_d    = 1'b1;
                        rom_addr_d = {3'b000, addr[7:0]};
                        read_pulse = 1'b1;
                    end
                end else begin
                    owner_d = 1'b0;
                end
            end
`ifdef SLOT_RESP_C8_EN
            else if (!io_strobe_n && owner_q) begin
                if (rw_n) begin
                    c8_rd_d    = 1'b1;
                    rom_addr_d = addr[10:0];
                    read_pulse = 1'b1;
                end
                // $CFFF releases the space after this access completes.
                if (addr == 16'hCFFF) begin
                    owner_d = 1'b0;
                end
            end
`endif
        end

        if (read_pulse) begin
            cnt_d = CNT_W'(RD_LATENCY);
        end

        if (!config_select_n) begin
            if (slot == 3'd0) begin
                state_d       = SCAN;
                configured_d  = 1'b0;
                owner_d       = 1'b0;
                data_out_en_d = 1'b0;
                matched_d     = 1'b0;
                cnt_d         = '0;
            end
            if (slot == 3'd0 || state_q == SCAN) begin
                if (card_id == CARD_ID) begin
                    my_slot_d = slot;
                    matched_d = 1'b1;
                end
                if (slot == 3'd7) begin
                    state_d      = matched_d ? ACTIVE : NOIDENT;
                    configured_d = matched_d;
                end
            end
        end
    end

    assign configured  = configured_q;
    assign my_slot     = my_slot_q;
    assign reg_wr      = reg_wr_q;
    assign reg_rd      = reg_rd_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign cn_rd       = cn_rd_q;
    assign c8_rd       = c8_rd_q;
    assign rom_addr    = rom_addr_q;
    assign c8_owner    = owner_q;
    assign data_out    = data_out_q;
    assign data_out_en = data_out_en_q;

endmodule

// File: tb/tb_slot_card_responder.sv
// Directed bench for slot_card_responder: three instances (ID 2/lat 2, ID 9/lat 1, ID 2/lat 3).
module tb_slot_card_responder;

`ifdef SLOT_RESP_C8_EN
    localparam bit C8_EN = 1'b1;
`else
    localparam bit C8_EN = 1'b0;
`endif

    logic        clk_logic = 1'b0;
    logic        system_reset_n;
    logic [2:0]  slot;
    logic [7:0]  card_id;
    logic        config_select_n, dev_select_n, io_select_n, io_strobe_n;
    logic [15:0] addr;
    logic        rw_n;
    logic [7:0]  data_in;
    logic        bus_strobe;
    logic [7:0]  rdata_i;

    logic        a_configured, a_reg_wr, a_reg_rd, a_cn_rd, a_c8_rd, a_c8_owner, a_data_out_en;
    logic [2:0]  a_my_slot;
    logic [3:0]  a_reg_addr;
    logic [7:0]  a_reg_wdata, a_data_out;
    logic [10:0] a_rom_addr;
    logic        b_configured, b_reg_wr, b_reg_rd, b_cn_rd, b_c8_rd, b_c8_owner, b_data_out_en;
    logic [2:0]  b_my_slot;
    logic [3:0]  b_reg_addr;
    logic [7:0]  b_reg_wdata, b_data_out;
    logic [10:0] b_rom_addr;
    logic        c_configured, c_reg_wr, c_reg_rd, c_cn_rd, c_c8_rd, c_c8_owner, c_data_out_en;
    logic [2:0]  c_my_slot;
    logic [3:0]  c_reg_addr;
    logic [7:0]  c_reg_wdata, c_data_out;
    logic [10:0] c_rom_addr;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 clk_logic = ~clk_logic;

    slot_card_responder #(.CARD_ID(8'd2), .RD_LATENCY(2)) dut_a (
        .clk_logic(clk_logic), .system_reset_n(system_reset_n), .slot(slot), .card_id(card_id),
        .config_select_n(config_select_n), .dev_select_n(dev_select_n), .io_select_n(io_select_n),
        .io_strobe_n(io_strobe_n), .addr(addr), .rw_n(rw_n), .data_in(data_in),
        .bus_strobe(bus_strobe), .rdata_i(rdata_i), .configured(a_configured), .my_slot(a_my_slot),
        .reg_wr(a_reg_wr), .reg_rd(a_reg_rd), .reg_addr(a_reg_addr), .reg_wdata(a_reg_wdata),
        .cn_rd(a_cn_rd), .c8_rd(a_c8_rd), .rom_addr(a_rom_addr), .c8_owner(a_c8_owner),
        .data_out(a_data_out), .data_out_en(a_data_out_en));

    slot_card_responder #(.CARD_ID(8'd9), .RD_LATENCY(1)) dut_b (
        .clk_logic(clk_logic), .system_reset_n(system_reset_n), .slot(slot), .card_id(card_id),
        .config_select_n(config_select_n), .dev_select_n(dev_select_n), .io_select_n(io_select_n),
        .io_strobe_n(io_strobe_n), .addr(addr), .rw_n(rw_n), .data_in(data_in),
        .bus_strobe(bus_strobe), .rdata_i(rdata_i), .configured(b_configured), .my_slot(b_my_slot),
        .reg_wr(b_reg_wr), .reg_rd(b_reg_rd), .reg_addr(b_reg_addr), .reg_wdata(b_reg_wdata),
        .cn_rd(b_cn_rd), .c8_rd(b_c8_rd), .rom_addr(b_rom_addr), .c8_owner(b_c8_owner),
        .data_out(b_data_out), .data_out_en(b_data_out_en));

    slot_card_responder #(.CARD_ID(8'd2), .RD_LATENCY(3)) dut_c (
        .clk_logic(clk_logic), .system_reset_n(system_reset_n), .slot(slot), .card_id(card_id),
        .config_select_n(config_select_n), .dev_select_n(dev_select_n), .io_select_n(io_select_n),
        .io_strobe_n(io_strobe_n), .addr(addr), .rw_n(rw_n), .data_in(data_in),
        .bus_strobe(bus_strobe), .rdata_i(rdata_i), .configured(c_configured), .my_slot(c_my_slot),
        .reg_wr(c_reg_wr), .reg_rd(c_reg_rd), .reg_addr(c_reg_addr), .reg_wdata(c_reg_wdata),
        .cn_rd(c_cn_rd), .c8_rd(c_c8_rd), .rom_addr(c_rom_addr), .c8_owner(c_c8_owner),
        .data_out(c_data_out), .data_out_en(c_data_out_en));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_logic);
        #1;
    endtask

    task automatic idle();
        config_select_n = 1'b1;
        dev_select_n    = 1'b1;
        io_select_n     = 1'b1;
        io_strobe_n     = 1'b1;
        bus_strobe      = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] s, input logic [7:0] id);
        slot = s;
        card_id = id;
        config_select_n = 1'b0;
        tick();
        idle();
    endtask

    // kind: 0 = device select, 1 = io select, 2 = io strobe
    task automatic bus(input logic [2:0] s, input int kind, input logic [15:0] a,
                       input logic r, input logic [7:0] d);
        slot = s;
        addr = a;
        rw_n = r;
        data_in = d;
        dev_select_n = (kind != 0);
        io_select_n  = (kind != 1);
        io_strobe_n  = (kind != 2);
        bus_strobe = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        logic seen_en;
        system_reset_n = 1'b0;
        slot = 3'd0; card_id = 8'd0; addr = 16'd0; rw_n = 1'b1; data_in = 8'd0; rdata_i = 8'h5A;
        idle();
        tick(); tick();
        check("rst_configured", 16'(a_configured), 16'd0);
        check("rst_my_slot", 16'(a_my_slot), 16'd0);
        check("rst_data_out_en", 16'(a_data_out_en), 16'd0);
        check("rst_rom_addr", 16'(a_rom_addr), 16'd0);
        system_reset_n = 1'b1;
        tick();

        // Scan: ID 2 lives in slot 4
        cfg(3'd0, 8'h00); cfg(3'd1, 8'h03); cfg(3'd2, 8'h00); cfg(3'd3, 8'h00);
        cfg(3'd4, 8'h02); cfg(3'd5, 8'h00); cfg(3'd6, 8'h00);
        check("scan_pre7_configured", 16'(a_configured), 16'd0);
        cfg(3'd7, 8'h05);
        check("scan_a_configured", 16'(a_configured), 16'd1);
        check("scan_a_my_slot", 16'(a_my_slot), 16'd4);
        check("scan_b_configured", 16'(b_configured), 16'd0);
        check("scan_c_my_slot", 16'(c_my_slot), 16'd4);

        bus(3'd4, 0, 16'hC0C0, 1'b1, 8'h00);
        check("c0c0_a_reg_rd", 16'(a_reg_rd), 16'd1);
        check("c0c0_b_reg_rd", 16'(b_reg_rd), 16'd0);

        bus(3'd4, 0, 16'hC0C3, 1'b0, 8'hA5);
        check("wr_reg_wr", 16'(a_reg_wr), 16'd1);
        check("wr_reg_addr", 16'(a_reg_addr), 16'd3);
        check("wr_reg_wdata", 16'(a_reg_wdata), 16'hA5);
        check("wr_b_reg_wr", 16'(b_reg_wr), 16'd0);
        check("wr_cancel_en", 16'(a_data_out_en), 16'd0);
        tick();
        check("wr_pulse_end", 16'(a_reg_wr), 16'd0);

        // Device read with fixed latency
        bus(3'd4, 0, 16'hC0C7, 1'b1, 8'h00);
        check("rd_reg_rd", 16'(a_reg_rd), 16'd1);
        check("rd_reg_addr", 16'(a_reg_addr), 16'd7);
        tick();
        check("rd_lat1_en", 16'(a_data_out_en), 16'd0);
        tick();
        check("rd_lat2_en", 16'(a_data_out_en), 16'd1);
        check("rd_lat2_data", 16'(a_data_out), 16'h5A);
        check("rd_c_lat2_en", 16'(c_data_out_en), 16'd0);
        tick();
        check("rd_c_lat3_en", 16'(c_data_out_en), 16'd1);
        check("rd_hold_en", 16'(a_data_out_en), 16'd1);
        bus(3'd5, 0, 16'hC0D0, 1'b0, 8'h11);
        check("rd_strobe_clr_a", 16'(a_data_out_en), 16'd0);
        check("rd_strobe_clr_c", 16'(c_data_out_en), 16'd0);
        check("foreign_dev_wr", 16'(a_reg_wr), 16'd0);

        // Expansion ROM ownership
        bus(3'd4, 1, 16'hC400, 1'b1, 8'h00);
        check("c400_cn_rd", 16'(a_cn_rd), 16'd1);
        check("c400_rom_addr", 16'(a_rom_addr), 16'h000);
        check("c400_owner", 16'(a_c8_owner), 16'(C8_EN));
        bus(3'd4, 2, 16'hC9AB, 1'b1, 8'h00);
        check("c9ab_c8_rd", 16'(a_c8_rd), 16'(C8_EN));
        check("c9ab_rom_addr", 16'(a_rom_addr), C8_EN ? 16'h1AB : 16'h000);
        bus(3'd4, 2, 16'hCFFF, 1'b1, 8'h00);
        check("cfff_c8_rd", 16'(a_c8_rd), 16'(C8_EN));
        check("cfff_rom_addr", 16'(a_rom_addr), C8_EN ? 16'h7FF : 16'h000);
        check("cfff_owner", 16'(a_c8_owner), 16'd0);
        bus(3'd4, 2, 16'hC900, 1'b1, 8'h00);
        check("c900_c8_rd", 16'(a_c8_rd), 16'd0);

        // Foreign slot io_select drops ownership
        bus(3'd4, 1, 16'hC400, 1'b1, 8'h00);
        check("own_again", 16'(a_c8_owner), 16'(C8_EN));
        bus(3'd3, 1, 16'hC300, 1'b1, 8'h00);
        check("foreign_owner", 16'(a_c8_owner), 16'd0);
        check("foreign_cn_rd", 16'(a_cn_rd), 16'd0);

        // Rescan while returning data; ID 2 now in slots 2 and 6, last wins
        bus(3'd4, 0, 16'hC0C1, 1'b1, 8'h00);
        tick(); tick();
        check("pre_rescan_en", 16'(a_data_out_en), 16'd1);
        cfg(3'd0, 8'h00);
        check("rescan_configured", 16'(a_configured), 16'd0);
        check("rescan_en", 16'(a_data_out_en), 16'd0);
        cfg(3'd1, 8'h00); cfg(3'd2, 8'h02); cfg(3'd3, 8'h00);
        cfg(3'd4, 8'h00); cfg(3'd5, 8'h00); cfg(3'd6, 8'h02); cfg(3'd7, 8'h00);
        check("rescan_recaptured", 16'(a_configured), 16'd1);
        check("rescan_my_slot", 16'(a_my_slot), 16'd6);
        check("rescan_b_configured", 16'(b_configured), 16'd0);

        // Cancel a pending read on the latency-3 instance
        bus(3'd6, 0, 16'hC0E1, 1'b1, 8'h00);
        check("cancel_c_reg_rd", 16'(c_reg_rd), 16'd1);
        tick();
        bus(3'd5, 0, 16'hC0D2, 1'b0, 8'h22);
        seen_en = c_data_out_en | a_data_out_en;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen_en = seen_en | c_data_out_en | a_data_out_en;
        end
        check("cancel_no_en", 16'(seen_en), 16'd0);

        // Asynchronous reset in the middle of a read
        bus(3'd6, 0, 16'hC0E2, 1'b1, 8'h00);
        check("midrd_reg_rd", 16'(a_reg_rd), 16'd1);
        #2 system_reset_n = 1'b0;
        #1;
        check("midrd_rst_reg_rd", 16'(a_reg_rd), 16'd0);
        check("midrd_rst_configured", 16'(a_configured), 16'd0);
        check("midrd_rst_my_slot", 16'(a_my_slot), 16'd0);
        check("midrd_rst_reg_addr", 16'(a_reg_addr), 16'd0);
        tick();
        system_reset_n = 1'b1;
        tick(); tick(); tick();
        check("post_rst_en", 16'(a_data_out_en), 16'd0);
        bus(3'd0, 0, 16'hC080, 1'b1, 8'h00);
        check("unconf_no_reg_rd", 16'(a_reg_rd), 16'd0);
        check("unconf_configured", 16'(a_configured), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
